stream_ctrl: RTL and testbench
==============================

// Module: stream_ctrl
// PURPOSE
//  Playback sequencer for the UART -> sample FIFO -> I2S audio path. Watches FIFO occupancy and
//  driver sample ticks; prefills before playback, gates consumption (play_en), drives DAC mute
//  with a pop-free unmute delay, recovers from underrun, toggles pause from btn1, and requests
//  XON/XOFF bytes on the UART transmitter. Sits between the FIFO, the driver and the UART.
// PARAMETERS
//  FIFO_AW     10       FIFO address width; fifo_level is FIFO_AW+1 bits (0..2^FIFO_AW)
//  PREFILL     512      level (bytes) required before playback starts/resumes
//  LOW_WM      128      level at/below which XON is requested (must be < HIGH_WM)
//  HIGH_WM     896      level at/above which XOFF is requested
//  UNMUTE_DLY  27000    clk cycles play_en runs with mute still asserted (1 ms @ 27 MHz)
//  DEBOUNCE    270000   clk cycles btn1 must be stable to register (10 ms)
//  XON_BYTE    8'h11    byte sent to resume host;  XOFF_BYTE 8'h13  byte sent to pause host
// PORTS
//  clk           in   1          system clock, 27 MHz
//  rst           in   1          synchronous reset, active-high
//  btn1          in   1          raw pause button, active-low, asynchronous
//  byte_ready    in   1          1-cycle pulse: byte written into FIFO
//  sample_tick   in   1          1-cycle pulse: driver consumes one sample
//  fifo_level    in   FIFO_AW+1  current FIFO occupancy
//  play_en       out  1          1 = driver may pop samples; 0 = driver outputs silence
//  mute          out  1          DAC mute, 1 = muted
//  tx_data       out  8          flow-control byte to UART TX
//  tx_valid      out  1          tx_data valid; held until tx_ready
//  tx_ready      in   1          UART TX accepts byte when tx_valid&tx_ready
//  state_o       out  3          current state encoding (for LEDs)
//  underrun_cnt  out  8          saturating underrun count
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, mute=1, play_en=0, tx_valid=0, tx_data=0, underrun_cnt=0,
//   xoff_sent=0, debounce counter=0, debounced btn=1. Reset mid-handshake drops pending byte.
//  All outputs registered; decisions use same-cycle inputs, effect visible 1 cycle later.
//  States (state_o): IDLE=0 PREFILL=1 UNMUTE=2 PLAY=3 PAUSE=4 UNDERRUN=5.
//   IDLE:     mute=1 play_en=0; byte_ready -> PREFILL.
//   PREFILL:  mute=1 play_en=0; fifo_level>=PREFILL -> UNMUTE, delay counter cleared.
//   UNMUTE:   play_en=1 mute=1; after UNMUTE_DLY cycles -> PLAY (mute=0).
//   PLAY:     play_en=1 mute=0; sample_tick with fifo_level==0 -> UNDERRUN; press -> PAUSE.
//             Underrun takes priority over a press in the same cycle.
//   UNDERRUN: one cycle; mute=1 play_en=0, underrun_cnt+=1 (saturates at 255) -> PREFILL.
//   PAUSE:    mute=1 play_en=0; press -> UNMUTE. Presses ignored in all other states except
//             PLAY (PLAY->PAUSE) and UNMUTE (UNMUTE->PAUSE).
//  Button: 2-FF synchroniser; debounced value updates after DEBOUNCE consecutive equal samples;
//   press = debounced 1->0 transition, one-cycle internal pulse. Held button = one press.
//  fifo_level arithmetic unsigned FIFO_AW+1 bits; full (2^FIFO_AW) counts as >= all watermarks.
// CONFIGURATION
//  STREAM_CTRL_FLOWCTL_EN defined: XON/XOFF flow control active, independent of state:
//   - !xoff_sent & fifo_level>=HIGH_WM & !tx_valid -> tx_data=XOFF_BYTE, tx_valid=1.
//   - xoff_sent & fifo_level<=LOW_WM & !tx_valid -> tx_data=XON_BYTE, tx_valid=1.
//   - tx_valid,tx_data stable until tx_valid&tx_ready; xoff_sent updates on that handshake;
//     tx_valid drops next cycle; no new request in the handshake cycle.
//   - Level crossing back while a byte is pending does not cancel it; hysteresis resolves next.
//  Not defined: tx_valid=0, tx_data=0 constant, no flow-control logic synthesised.
// TESTING (FIFO_AW=4 PREFILL=8 LOW_WM=4 HIGH_WM=12 UNMUTE_DLY=4 DEBOUNCE=3)
//  Reset, byte_ready, level ramps 1..8 -> PREFILL until level 8; play_en=1 next cycle,
//   mute=0 exactly 4 cycles later, state_o=3.
//  PLAY, level=0 with sample_tick -> state_o=5 one cycle, mute=1, play_en=0, underrun_cnt=1,
//   then PREFILL; repeat 260 underruns -> underrun_cnt stays 255.
//  FLOWCTL_EN, level 12, tx_ready=0 for 5 cycles -> tx_valid=1, tx_data=8'h13 held; tx_ready=1
//   -> handshake, tx_valid=0 next; level 4 -> 8'h11 sent once; level 8 -> nothing sent.
//  btn1 low 2 cycles (glitch) in PLAY -> no change; low 10 cycles -> PAUSE (mute=1, play_en=0);
//   release/press again -> UNMUTE, PLAY after 4 cycles.
//  Same-cycle underrun and debounced press in PLAY -> UNDERRUN, not PAUSE.
//  rst=1 during pending XOFF and PLAY -> next cycle tx_valid=0, mute=1, state_o=0, cnt=0.

Source files
------------

// File: rtl/stream_ctrl.sv
// stream_ctrl: playback sequencer for the UART -> sample FIFO -> I2S path.
// Prefills the FIFO, gates sample consumption, holds the DAC muted for a
// pop-free interval after playback starts, recovers from underrun, toggles
// pause from a debounced button and (optionally) throttles the host with
// XON/XOFF bytes.
//
// Build option: define STREAM_CTRL_FLOWCTL_EN to include the XON/XOFF
// requester. Without it tx_valid and tx_data are tied to zero.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for the first byte after reset
// PREFL | muted, waiting for the FIFO to reach the prefill level
// UNMUT | driver popping samples, DAC still muted for UNMUTE_DLY cycles
// PLAY  | normal playback, DAC unmuted
// PAUSE | user pause, muted and not popping
// UNDER | single-cycle underrun marker, bumps the underrun counter
module stream_ctrl #(
    parameter int unsigned FIFO_AW    = 10,
    parameter int unsigned PREFILL    = 512,
    parameter int unsigned LOW_WM     = 128,
    parameter int unsigned HIGH_WM    = 896,
    parameter int unsigned UNMUTE_DLY = 27000,
    parameter int unsigned DEBOUNCE   = 270000,
    parameter logic [7:0]  XON_BYTE   = 8'h11,
    parameter logic [7:0]  XOFF_BYTE  = 8'h13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn1,
    input  logic             byte_ready,
    input  logic             sample_tick,
    input  logic [FIFO_AW:0] fifo_level,
    output logic             play_en,
    output logic             mute,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [2:0]       state_o,
    output logic [7:0]       underrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREFILL  = 3'd1,
        S_UNMUTE   = 3'd2,
        S_PLAY     = 3'd3,
        S_PAUSE    = 3'd4,
        S_UNDERRUN = 3'd5
    } state_t;

    localparam int unsigned LW    = FIFO_AW + 1;
    localparam int unsigned DLY_W = (UNMUTE_DLY > 1) ? $clog2(UNMUTE_DLY) : 1;
    localparam int unsigned DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    // Thresholds in fifo_level width; a completely full FIFO (2^FIFO_AW)
    // is representable and compares as above every watermark.
    localparam logic [LW-1:0]    PREFILL_LV = LW'(PREFILL);
    localparam logic [LW-1:0]    LOW_LV     = LW'(LOW_WM);
    localparam logic [LW-1:0]    HIGH_LV    = LW'(HIGH_WM);
    localparam logic [DLY_W-1:0] DLY_LOAD   = DLY_W'(UNMUTE_DLY - 1);
    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE - 1);

    state_t           state;
    state_t           state_next;
    logic [DLY_W-1:0] dly_cnt;

    logic             btn_meta;
    logic             btn_sync;
    logic             btn_db;
    logic             btn_db_q;
    logic [DB_W-1:0]  db_cnt;
    logic             press;

    logic             mute_d;
    logic             play_en_d;
    logic             underrun_hit;

    // ------------------------------------------------------------------
    // Button: synchronise, debounce, and turn a falling edge into a pulse
    // ------------------------------------------------------------------

    // Two-flop synchroniser for the asynchronous button (idle level is high).
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
        end else begin
            btn_meta <= btn1;
            btn_sync <= btn_meta;
        end
    end

    // Accept a new button level only after DEBOUNCE consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b1;
            btn_db_q <= 1'b1;
        end else begin
            btn_db_q <= btn_db;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Button is active-low: a press is the debounced 1 -> 0 transition.
    assign press = btn_db_q & ~btn_db;

    // ------------------------------------------------------------------
    // Playback FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Unmute delay: reload on every entry into UNMUTE, count down to zero there.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_cnt <= '0;
        end else if (state_next == S_UNMUTE && state != S_UNMUTE) begin
            dly_cnt <= DLY_LOAD;
        end else if (state == S_UNMUTE && dly_cnt != '0) begin
            dly_cnt <= dly_cnt - 1'b1;
        end
    end

    // Next-state decision from the current state and same-cycle inputs.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (byte_ready) state_next = S_PREFILL;
            end
            S_PREFILL: begin
                if (fifo_level >= PREFILL_LV) state_next = S_UNMUTE;
            end
            S_UNMUTE: begin
                if (press)               state_next = S_PAUSE;
                else if (dly_cnt == '0)  state_next = S_PLAY;
            end
            S_PLAY: begin
                // Starvation wins over a coincident press.
                if (sample_tick && fifo_level == '0) state_next = S_UNDERRUN;
                else if (press)                      state_next = S_PAUSE;
            end
            S_UNDERRUN: begin
                state_next = S_PREFILL;
            end
            S_PAUSE: begin
                if (press) state_next = S_UNMUTE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode for the state being entered, so outputs can be registered.
    always_comb begin
        mute_d       = 1'b1;
        play_en_d    = 1'b0;
        underrun_hit = 1'b0;
        case (state_next)
            S_UNMUTE: begin
                play_en_d = 1'b1;
            end
            S_PLAY: begin
                play_en_d = 1'b1;
                mute_d    = 1'b0;
            end
            S_UNDERRUN: begin
                underrun_hit = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Registered playback outputs and saturating underrun counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mute         <= 1'b1;
            play_en      <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            mute    <= mute_d;
            play_en <= play_en_d;
            if (underrun_hit && underrun_cnt != 8'hFF) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end
    end

    assign state_o = state;

    // ------------------------------------------------------------------
    // XON/XOFF flow control
    // ------------------------------------------------------------------
`ifdef STREAM_CTRL_FLOWCTL_EN
    logic xoff_sent;

    // One byte in flight at a time; hysteresis state changes only on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            xoff_sent <= 1'b0;
        end else if (tx_valid) begin
            if (tx_ready) begin
                tx_valid  <= 1'b0;
                xoff_sent <= (tx_data == XOFF_BYTE);
            end
        end else if (!xoff_sent && fifo_level >= HIGH_LV) begin
            tx_data  <= XOFF_BYTE;
            tx_valid <= 1'b1;
        end else if (xoff_sent && fifo_level <= LOW_LV) begin
            tx_data  <= XON_BYTE;
            tx_valid <= 1'b1;
        end
    end
`else
    logic flowctl_unused;

    assign tx_valid       = 1'b0;
    assign tx_data        = '0;
    assign flowctl_unused = tx_ready ^ (^LOW_LV) ^ (^HIGH_LV) ^ (^XON_BYTE) ^ (^XOFF_BYTE);
`endif

endmodule

// File: tb/tb_stream_ctrl.sv
// Directed bench for stream_ctrl with small parameters
// (FIFO_AW=4 PREFILL=8 LOW_WM=4 HIGH_WM=12 UNMUTE_DLY=4 DEBOUNCE=3).
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// Flow-control expectations follow STREAM_CTRL_FLOWCTL_EN.
module tb_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn1;
    logic       byte_ready;
    logic       sample_tick;
    logic [4:0] fifo_level;
    logic       play_en;
    logic       mute;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] state_o;
    logic [7:0] underrun_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    stream_ctrl #(
        .FIFO_AW    (4),
        .PREFILL    (8),
        .LOW_WM     (4),
        .HIGH_WM    (12),
        .UNMUTE_DLY (4),
        .DEBOUNCE   (3),
        .XON_BYTE   (8'h11),
        .XOFF_BYTE  (8'h13)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn1         (btn1),
        .byte_ready   (byte_ready),
        .sample_tick  (sample_tick),
        .fifo_level   (fifo_level),
        .play_en      (play_en),
        .mute         (mute),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .state_o      (state_o),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise the level to the prefill point and wait (bounded) for PLAY.
    task automatic go_play(input string tag);
        int k;
        fifo_level = 5'd8;
        k = 0;
        while (state_o != 3'd3 && k < 50) begin
            step(1);
            k++;
        end
        chk(tag, state_o, 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         nv;
        logic [7:0] last_d;

        rst         = 1'b1;
        btn1        = 1'b1;
        byte_ready  = 1'b0;
        sample_tick = 1'b0;
        tx_ready    = 1'b1;
        fifo_level  = 5'd0;
        step(2);
        chk("rst_state", state_o, 0);
        chk("rst_mute", mute, 1);
        chk("rst_play_en", play_en, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_ucnt", underrun_cnt, 0);

        rst = 1'b0;
        step(1);
        chk("idle_hold", state_o, 0);

        // Prefill ramp 1..8
        byte_ready = 1'b1;
        fifo_level = 5'd1;
        step(1);
        chk("prefill_enter", state_o, 1);
        for (int lv = 2; lv <= 7; lv++) begin
            fifo_level = 5'(lv);
            step(1);
            chk("prefill_hold", state_o, 1);
            chk("prefill_play_en", play_en, 0);
        end
        byte_ready = 1'b0;
        fifo_level = 5'd8;
        step(1);
        chk("unmute_state", state_o, 2);
        chk("unmute_play_en", play_en, 1);
        chk("unmute_mute", mute, 1);
        step(3);
        chk("unmute_still_muted", mute, 1);
        chk("unmute_still_state", state_o, 2);
        step(1);
        chk("play_mute", mute, 0);
        chk("play_state", state_o, 3);
        chk("play_play_en", play_en, 1);

        // Single underrun
        fifo_level  = 5'd0;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        fifo_level  = 5'd3;
        chk("ur_state", state_o, 5);
        chk("ur_mute", mute, 1);
        chk("ur_play_en", play_en, 0);
        chk("ur_cnt1", underrun_cnt, 1);
        step(1);
        chk("ur_to_prefill", state_o, 1);

        // Tick with data available is not an underrun
        go_play("replay_a");
        fifo_level  = 5'd5;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk("tick_nonempty", state_o, 3);

        // 259 more underruns: counter reaches 254, then saturates at 255
        for (int i = 0; i < 259; i++) begin
            go_play("replay_loop");
            fifo_level  = 5'd0;
            sample_tick = 1'b1;
            step(1);
            sample_tick = 1'b0;
            if (i == 252) chk("ur_cnt254", underrun_cnt, 254);
        end
        chk("ur_cnt_sat", underrun_cnt, 255);
        go_play("replay_b");

        // Two-cycle glitch is filtered
        btn1 = 1'b0;
        step(2);
        btn1 = 1'b1;
        step(8);
        chk("glitch_ignored", state_o, 3);

        // Long press -> PAUSE
        btn1 = 1'b0;
        step(10);
        chk("pause_state", state_o, 4);
        chk("pause_mute", mute, 1);
        chk("pause_play_en", play_en, 0);
        btn1 = 1'b1;
        step(8);
        chk("release_stays_pause", state_o, 4);

        // Press again -> UNMUTE, PLAY 4 cycles later
        btn1 = 1'b0;
        step(6);
        chk("resume_unmute", state_o, 2);
        chk("resume_play_en", play_en, 1);
        chk("resume_mute", mute, 1);
        step(3);
        chk("resume_still_unmute", state_o, 2);
        step(1);
        chk("resume_play", state_o, 3);
        chk("resume_unmuted", mute, 0);
        btn1 = 1'b1;
        step(8);
        chk("release_stays_play", state_o, 3);

        // Debounced press lands in the same cycle as an underrun
        btn1 = 1'b0;
        step(5);
        fifo_level  = 5'd0;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        fifo_level  = 5'd3;
        chk("tie_underrun", state_o, 5);
        chk("tie_cnt", underrun_cnt, 255);
        step(1);
        chk("tie_prefill", state_o, 1);
        btn1 = 1'b1;
        step(8);
        chk("tie_no_pause", state_o, 1);

        // Reset while playing with an XOFF pending
        go_play("replay_c");
        fifo_level = 5'd12;
        tx_ready   = 1'b0;
        step(1);
`ifdef STREAM_CTRL_FLOWCTL_EN
        chk("pend_valid", tx_valid, 1);
`else
        chk("pend_valid", tx_valid, 0);
`endif
        rst = 1'b1;
        step(1);
        chk("mrst_tx_valid", tx_valid, 0);
        chk("mrst_tx_data", tx_data, 0);
        chk("mrst_mute", mute, 1);
        chk("mrst_play_en", play_en, 0);
        chk("mrst_state", state_o, 0);
        chk("mrst_cnt", underrun_cnt, 0);
        rst        = 1'b0;
        tx_ready   = 1'b1;
        fifo_level = 5'd0;
        step(1);

        // Flow control: one below HIGH_WM requests nothing
        fifo_level = 5'd11;
        tx_ready   = 1'b0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (tx_valid) nv++;
        end
        chk("fc_below_high", nv, 0);

        // Level 12, sink stalled for 5 cycles
        fifo_level = 5'd12;
        step(1);
`ifdef STREAM_CTRL_FLOWCTL_EN
        chk("fc_xoff_valid", tx_valid, 1);
        chk("fc_xoff_data", tx_data, 8'h13);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("fc_xoff_hold_v", tx_valid, 1);
            chk("fc_xoff_hold_d", tx_data, 8'h13);
        end
`else
        chk("fc_off_valid", tx_valid, 0);
        chk("fc_off_data", tx_data, 0);
        step(5);
`endif
        tx_ready = 1'b1;
        step(1);
        chk("fc_after_hs", tx_valid, 0);
        nv = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (tx_valid) nv++;
        end
        chk("fc_no_repeat_xoff", nv, 0);

        // Drop to LOW_WM: exactly one XON
        fifo_level = 5'd4;
        nv = 0;
        last_d = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (tx_valid) begin
                nv++;
                last_d = tx_data;
            end
        end
`ifdef STREAM_CTRL_FLOWCTL_EN
        chk("fc_xon_count", nv, 1);
        chk("fc_xon_data", last_d, 8'h11);
`else
        chk("fc_xon_count", nv, 0);
        chk("fc_xon_data", tx_data, 0);
`endif

        // Mid-band level: nothing
        fifo_level = 5'd8;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (tx_valid) nv++;
        end
        chk("fc_midband", nv, 0);

        // Full FIFO counts as above HIGH_WM
        fifo_level = 5'd16;
        step(1);
`ifdef STREAM_CTRL_FLOWCTL_EN
        chk("fc_full_valid", tx_valid, 1);
        chk("fc_full_data", tx_data, 8'h13);
`else
        chk("fc_full_valid", tx_valid, 0);
        chk("fc_full_data", tx_data, 0);
`endif
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
